// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D memory-port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

  // Grant identifiers, also used as the value of the round-robin priority pointer
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    GAP     = 2'd3
  } arb_state_t;

  // Choose the side to grant when at least one side is pending.
  // prio names the side that wins a tie.
  function automatic logic pick_side(input logic i_pend, input logic d_pend, input logic prio);
    logic side;
    if (d_pend && (!i_pend || prio == GNT_D)) side = GNT_D;
    else                                      side = GNT_I;
    return side;
  endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// Clear/enable saturating counter for the arbiter's grant watchdog.
// tc is asserted in the enabled cycle whose increment lands the count on
// TIMEOUT_CYC, so a flag registered from it becomes visible in the same
// cycle the count reaches the terminal value.
module arb_timeout_cnt #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TC_PREV = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count;

  // Count enabled cycles, hold at the terminal value, restart on clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        count <= '0;
    else if (clr)                    count <= '0;
    else if (en && count != TC_VAL)  count <= count + CNT_W'(1);
  end

  assign tc = en && !clr && (count == TC_PREV);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one line-wide backing-memory port between the I-cache and D-cache.
// A granted side owns the port from issue until mem_ready, followed by one
// idle GAP cycle so the served cache can drop its request.
// Optional feature: define ARB_ROUND_ROBIN_EN for alternating tie-break;
// otherwise the D-cache always wins a tie.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              timeout_err
);

  arb_state_t state, state_nxt;
  logic       i_pend, d_pend;
  logic       prio, win_side;
  logic       granted;
  logic       tc;

  assign i_pend  = i_read | i_write;
  assign d_pend  = d_read | d_write;
  assign granted = (state == GRANT_I) || (state == GRANT_D);

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_prio;

  // Hand tie priority to the side that was not served last
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                rr_prio <= GNT_D;
    else if (mem_ready && state == GRANT_I)  rr_prio <= GNT_D;
    else if (mem_ready && state == GRANT_D)  rr_prio <= GNT_I;
  end

  assign prio = rr_prio;
`else
  assign prio = GNT_D;
`endif

  assign win_side = pick_side(i_pend, d_pend, prio);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and port decode; the granted side drives memory directly
  always_comb begin
    state_nxt = state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (i_pend || d_pend) state_nxt = (win_side == GNT_D) ? GRANT_D : GRANT_I;
      end
      GRANT_I: begin
        mem_write = i_write;
        mem_read  = i_read & ~i_write;
        mem_addr  = i_addr;
        mem_wdata = i_wdata;
        i_ready   = mem_ready;
        if (mem_ready) state_nxt = GAP;
      end
      GRANT_D: begin
        mem_write = d_write;
        mem_read  = d_read & ~d_write;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_ready   = mem_ready;
        if (mem_ready) state_nxt = GAP;
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  // Grant watchdog: restarts whenever no grant is held
  arb_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (~granted),
    .en  (granted),
    .tc  (tc)
  );

  // Sticky timeout flag; the grant itself is never forced off
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  timeout_err <= 1'b0;
    else if (tc && !mem_ready) timeout_err <= 1'b1;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a scoreboard monitor.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, i_write, d_read, d_write;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [DW-1:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic          i_ready, d_ready, mem_read, mem_write, mem_ready, busy, timeout_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct { logic side; logic [DW-1:0] data; } rdy_t;
  typedef struct { logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; } iss_t;

  rdy_t rdy_q[$];
  iss_t iss_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_iss(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] w);
    iss_t s;
    s.wr = wr; s.addr = a; s.wdata = w;
    iss_q.push_back(s);
  endtask

  task automatic push_rdy(input logic side, input logic [DW-1:0] d);
    rdy_t r;
    r.side = side; r.data = d;
    rdy_q.push_back(r);
  endtask

  // Monitor: pops expected issues and completions as the DUT presents them
  initial begin
    logic op_prev, rdy_prev;
    rdy_t r;
    iss_t s;
    op_prev  = 1'b0;
    rdy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        op_prev  = 1'b0;
        rdy_prev = 1'b0;
      end else begin
        chk("rd_wr_exclusive", mem_read & mem_write, 0);
        chk("ready_exclusive", i_ready & d_ready, 0);
        if (rdy_prev) begin
          chk("gap_no_op", mem_read | mem_write, 0);
          chk("gap_busy", busy, 1);
        end
        if (i_ready | d_ready) begin
          if (rdy_q.size() == 0) chk("unexpected_ready", 1, 0);
          else begin
            r = rdy_q.pop_front();
            chk("ready_side", d_ready, r.side);
            chk("ready_rdata", d_ready ? d_rdata : i_rdata, r.data);
          end
        end
        if ((mem_read | mem_write) && !op_prev) begin
          if (iss_q.size() == 0) chk("unexpected_issue", 1, 0);
          else begin
            s = iss_q.pop_front();
            chk("issue_write", mem_write, s.wr);
            chk("issue_addr", mem_addr, s.addr);
            chk("issue_wdata", mem_wdata, s.wdata);
          end
        end
        op_prev  = mem_read | mem_write;
        rdy_prev = i_ready | d_ready;
      end
    end
  end

  // Protocol note for a side raising read and write together
  initial forever begin
    @(negedge clk);
    if (rst === 1'b1 && i_read && i_write) $display("protocol: I-side read and write together at %0t", $time);
    if (rst === 1'b1 && d_read && d_write) $display("protocol: D-side read and write together at %0t", $time);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic exp_side [4];

  initial begin
    int act;
    rst = 1'b0;
    i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
    d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) tick();

    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout_err, 0);
    rst = 1'b1;

    // Idle: nothing requested for 20 cycles
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_read | mem_write | busy | i_ready | d_ready) act++;
      tick();
    end
    chk("idle_quiet", act, 0);

    // Single I read, answered in the fifth grant cycle
    i_read = 1; i_addr = 28'h0000010; i_wdata = 128'h11;
    push_iss(1'b0, 28'h0000010, 128'h11);
    @(negedge clk);
    chk("lat_req_cycle", mem_read, 0);
    tick();
    @(negedge clk);
    chk("lat_next_cycle", mem_read, 1);
    chk("single_addr", mem_addr, 28'h0000010);
    chk("single_busy", busy, 1);
    repeat (4) tick();
    mem_rdata = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666; mem_ready = 1;
    push_rdy(GNT_I, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666);
    @(negedge clk);
    chk("rdata_broadcast", d_rdata, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666);
    tick(); mem_ready = 0; i_read = 0;
    tick();
    @(negedge clk);
    chk("single_back_idle", busy, 0);

    // mem_ready with no grant is ignored
    tick(); mem_ready = 1;
    @(negedge clk);
    chk("stray_ready_i", i_ready, 0);
    chk("stray_ready_d", d_ready, 0);
    chk("stray_ready_busy", busy, 0);
    tick(); mem_ready = 0;

    // Simultaneous I read and D write: D first, then I
    i_read = 1; i_addr = 28'h0000020; i_wdata = '0;
    d_write = 1; d_addr = 28'h0ABCDEF; d_wdata = 128'hDEAD_BEEF_0000_0001;
    push_iss(1'b1, 28'h0ABCDEF, 128'hDEAD_BEEF_0000_0001);
    push_iss(1'b0, 28'h0000020, '0);
    tick();
    mem_ready = 1; mem_rdata = 128'h1;
    push_rdy(GNT_D, 128'h1);
    @(negedge clk);
    chk("tie_d_write_first", mem_write, 1);
    tick(); mem_ready = 0; d_write = 0;
    tick();
    tick();
    tick(); mem_ready = 1; mem_rdata = 128'h2;
    push_rdy(GNT_I, 128'h2);
    tick(); mem_ready = 0; i_read = 0;
    tick();

    // I drops its request before mem_ready; grant is held
    i_read = 1; i_addr = 28'h0000030; i_wdata = '0;
    push_iss(1'b0, 28'h0000030, '0);
    tick();
    @(negedge clk);
    chk("drop_granted", mem_read, 1);
    tick(); i_read = 0;
    @(negedge clk);
    chk("drop_read_low", mem_read, 0);
    chk("drop_still_busy", busy, 1);
    tick(); mem_ready = 1; mem_rdata = 128'h3;
    push_rdy(GNT_I, 128'h3);
    tick(); mem_ready = 0;
    tick();
    @(negedge clk);
    chk("drop_back_idle", busy, 0);

    // D raises read and write together: the write is issued
    d_read = 1; d_write = 1; d_addr = 28'h0000040; d_wdata = 128'hCAFE;
    push_iss(1'b1, 28'h0000040, 128'hCAFE);
    tick();
    @(negedge clk);
    chk("rw_read_suppressed", mem_read, 0);
    chk("rw_write_issued", mem_write, 1);
    tick(); mem_ready = 1; mem_rdata = 128'h4;
    push_rdy(GNT_D, 128'h4);
    tick(); mem_ready = 0; d_read = 0; d_write = 0;
    tick();

    // Asynchronous reset in the middle of a D grant
    d_read = 1; d_addr = 28'h0000050; d_wdata = '0;
    push_iss(1'b0, 28'h0000050, '0);
    tick();
    @(negedge clk);
    chk("mid_rst_pre_busy", busy, 1);
    #1; rst = 0; mem_ready = 1; #1;
    chk("mid_rst_mem_read", mem_read, 0);
    chk("mid_rst_mem_write", mem_write, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_mem_wdata", mem_wdata, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_d_ready", d_ready, 0);
    chk("mid_rst_i_ready", i_ready, 0);
    d_read = 0; mem_ready = 0;
    tick();
    tick(); rst = 1;
    i_read = 1; i_addr = 28'h0000060; i_wdata = '0;
    push_iss(1'b0, 28'h0000060, '0);
    @(negedge clk);
    chk("post_rst_req_cycle", mem_read, 0);
    tick();
    @(negedge clk);
    chk("post_rst_next_cycle", mem_read, 1);
    tick(); mem_ready = 1; mem_rdata = 128'h5;
    push_rdy(GNT_I, 128'h5);
    tick(); mem_ready = 0; i_read = 0;
    tick();

    // Both sides requesting continuously for four transactions
`ifdef ARB_ROUND_ROBIN_EN
    exp_side[0] = GNT_D; exp_side[1] = GNT_I; exp_side[2] = GNT_D; exp_side[3] = GNT_I;
`else
    exp_side[0] = GNT_D; exp_side[1] = GNT_D; exp_side[2] = GNT_D; exp_side[3] = GNT_D;
`endif
    i_read = 1; i_addr = 28'h0000070; i_wdata = '0;
    d_read = 1; d_addr = 28'h0000080; d_wdata = '0;
    for (int k = 0; k < 4; k++)
      push_iss(1'b0, (exp_side[k] == GNT_D) ? 28'h0000080 : 28'h0000070, '0);
    for (int k = 0; k < 4; k++) begin
      tick(); mem_ready = 1; mem_rdata = DW'(100 + k);
      push_rdy(exp_side[k], DW'(100 + k));
      tick(); mem_ready = 0;
      if (k == 3) begin i_read = 0; d_read = 0; end
      tick();
    end

    // Memory never answers: sticky timeout in the ninth grant cycle
    d_read = 1; d_addr = 28'h0000090; d_wdata = '0;
    push_iss(1'b0, 28'h0000090, '0);
    for (int g = 1; g <= 12; g++) begin
      tick();
      @(negedge clk);
      chk($sformatf("timeout_g%0d", g), timeout_err, (g >= 9) ? 1 : 0);
    end
    chk("timeout_busy", busy, 1);
    tick(); mem_ready = 1; mem_rdata = 128'h6;
    push_rdy(GNT_D, 128'h6);
    tick(); mem_ready = 0; d_read = 0;
    tick();
    @(negedge clk);
    chk("timeout_done_idle", busy, 0);
    chk("timeout_sticky", timeout_err, 1);

    tick();
    chk("ready_queue_drained", rdy_q.size(), 0);
    chk("issue_queue_drained", iss_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
